// File: rtl/div_2c_pkg.sv
// div_2c_pkg: shared widths, saturation constants and FSM states for the Q17.14 divider.
package div_2c_pkg;
  localparam int WIDTH = 32;
  localparam int FRAC = 14;
  localparam int ITER = WIDTH + FRAC;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [WIDTH-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [WIDTH-1:0] SAT_MIN = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/abs_2c_32b.sv
// abs_2c_32b: two's complement to sign + unsigned magnitude (most negative value maps exactly).
module abs_2c_32b #(
  parameter int WIDTH = div_2c_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic             sign,
  output logic [WIDTH-1:0] mag
);
  assign sign = a[WIDTH-1];
  assign mag = sign ? -a : a;
endmodule

// File: rtl/div_2c_32b.sv
// div_2c_32b: sequential Q17.14 signed divider, restoring, one quotient bit per cycle,
// with saturation and divide-by-zero flags.
module div_2c_32b #(
  parameter int WIDTH = div_2c_pkg::WIDTH,
  parameter int FRAC = div_2c_pkg::FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d_out,
  output logic             dz,
  output logic             ovf
);
  import div_2c_pkg::*;
  localparam int N = WIDTH + FRAC;
  localparam int C = $clog2(N + 1);
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state, state_n;
  logic [C-1:0] cnt;
  logic [N-1:0] dq, q_n;
  logic [WIDTH-1:0] rem, rem_n, ay, ax_c, ay_c, res;
  logic [WIDTH:0] trial, diff;
  logic sx, sy, sx_c, sy_c, fit, last, neg, yz, big_pos, big_neg, ovf_n;
  abs_2c_32b #(.WIDTH(WIDTH)) u_abs_x (.a(x), .sign(sx_c), .mag(ax_c));
  abs_2c_32b #(.WIDTH(WIDTH)) u_abs_y (.a(y), .sign(sy_c), .mag(ay_c));
  // dq shifts the dividend out at the top while quotient bits enter at the bottom
  assign trial = {rem, dq[N-1]};
  assign diff = trial - {1'b0, ay};
  assign fit = trial >= {1'b0, ay};
  assign rem_n = fit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_n = {dq[N-2:0], fit};
  assign last = state == BUSY && cnt == C'(N - 1);
  assign neg = sx ^ sy;
  assign yz = ay == '0;
  assign big_pos = |q_n[N-1:WIDTH-1];
  assign big_neg = |q_n[N-1:WIDTH] || (q_n[WIDTH-1] && |q_n[WIDTH-2:0]);
  assign ovf_n = !yz && (neg ? big_neg : big_pos);
  assign res = yz ? (sx ? MINV : MAXV) : ovf_n ? (neg ? MINV : MAXV) :
               neg ? -q_n[WIDTH-1:0] : q_n[WIDTH-1:0];
  assign busy = state == BUSY;
  assign done = state == DONE;
  always_comb begin
    state_n = IDLE;
    if (state == IDLE) state_n = start ? BUSY : IDLE;
    else if (state == BUSY) state_n = last ? DONE : BUSY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      dq <= '0;
      rem <= '0;
      ay <= '0;
      sx <= 1'b0;
      sy <= 1'b0;
      d_out <= '0;
      dz <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        dq <= {ax_c, {FRAC{1'b0}}};
        rem <= '0;
        ay <= ay_c;
        sx <= sx_c;
        sy <= sy_c;
        cnt <= '0;
      end else if (state == BUSY) begin
        dq <= q_n;
        rem <= rem_n;
        cnt <= cnt + C'(1);
      end
      if (last) begin
        d_out <= res;
        dz <= yz;
        ovf <= ovf_n;
      end
    end
  end
endmodule

// File: tb/tb_div_2c_32b.sv
// tb_div_2c_32b: directed vectors for the Q17.14 divider with hand-computed results.
module tb_div_2c_32b;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic busy, done, dz, ovf;
  logic [31:0] d_out;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  div_2c_32b dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .d_out(d_out), .dz(dz), .ovf(ovf)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // leaves the bench at the sample point of the first cycle after the accepting edge
  task automatic launch(input logic [31:0] xv, input logic [31:0] yv);
    @(negedge clk);
    x = xv;
    y = yv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = ~xv;
    y = 32'h0000_1234;
  endtask
  task automatic wait_done(input int from, output int lat, output int bc);
    lat = from;
    bc = 0;
    while (!done && lat < 100) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                     input logic [31:0] ed, input logic edz, input logic eovf);
    int lat, bc;
    launch(xv, yv);
    wait_done(1, lat, bc);
    check({tag, " latency"}, lat, 47);
    check({tag, " busy cycles"}, bc, 46);
    check({tag, " d_out"}, d_out, ed);
    check({tag, " dz"}, {31'b0, dz}, {31'b0, edz});
    check({tag, " ovf"}, {31'b0, ovf}, {31'b0, eovf});
  endtask
  initial begin
    int lat, bc, nd;
    repeat (3) @(negedge clk);
    check("reset d_out", d_out, 0);
    check("reset busy", {31'b0, busy}, 0);
    check("reset done", {31'b0, done}, 0);
    check("reset dz", {31'b0, dz}, 0);
    check("reset ovf", {31'b0, ovf}, 0);
    rst_n = 1'b1;
    run("basic", 32'h0002_8F5C, 32'h0001_4000, 32'h0000_8312, 1'b0, 1'b0);
    run("neg trunc", 32'hFFFF_699A, 32'h0001_4000, 32'hFFFF_E1EC, 1'b0, 1'b0);
    run("dz pos", 32'h0001_4000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run("dz neg", 32'hFFFF_699A, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);
    run("dz zero", 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run("ovf pos", 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run("min exact", 32'h8000_0000, 32'h0000_4000, 32'h8000_0000, 1'b0, 1'b0);
    run("ovf pos 2^31", 32'h8000_0000, 32'hFFFF_C000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run("ovf neg", 32'h8000_0000, 32'h0000_2000, 32'h8000_0000, 1'b0, 1'b1);
    run("neg zero", 32'hFFFF_FFFF, 32'h0001_4000, 32'h0000_0000, 1'b0, 1'b0);
    run("third", 32'h0000_4000, 32'h0000_C000, 32'h0000_1555, 1'b0, 1'b0);
    run("prime", 32'h0002_8F5C, 32'h0001_4000, 32'h0000_8312, 1'b0, 1'b0);
    // stray start while busy and while done must not be taken
    launch(32'h0000_4000, 32'h0000_C000);
    repeat (9) @(negedge clk);
    x = 32'h0001_4000;
    y = 32'h0000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    check("hold d_out", d_out, 32'h0000_8312);
    check("hold dz", {31'b0, dz}, 0);
    wait_done(40, lat, bc);
    check("ignore latency", lat, 47);
    check("ignore d_out", d_out, 32'h0000_1555);
    check("ignore dz", {31'b0, dz}, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start in done", {31'b0, busy}, 0);
    nd = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("no queued done", nd, 0);
    // reset during a divide aborts it
    launch(32'h0002_8F5C, 32'h0001_4000);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort d_out", d_out, 0);
    check("abort busy", {31'b0, busy}, 0);
    check("abort done", {31'b0, done}, 0);
    check("abort dz", {31'b0, dz}, 0);
    check("abort ovf", {31'b0, ovf}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort no done", nd, 0);
    run("after reset", 32'h0002_8F5C, 32'h0001_4000, 32'h0000_8312, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
